// File: rtl/tmr_pkg.sv
// Shared constants and helpers for the tmr_param timer/counter.
package tmr_pkg;

  typedef enum logic {
    EDGE_RISE = 1'b0,
    EDGE_FALL = 1'b1
  } edge_sel_e;

  typedef enum logic {
    SRC_INT = 1'b0,
    SRC_EXT = 1'b1
  } src_sel_e;

  // Increment requests dropped after a register write
  localparam int unsigned INHIBIT_CYCLES = 2;

  // Prescale ratio selected by ps: 2^(ps+1)
  function automatic int unsigned ps_ratio(input int unsigned ps);
    return 32'd1 << (ps + 32'd1);
  endfunction

endpackage

// File: rtl/tmr_edge_sync.sv
// Synchronises the external count pin into the oscIn domain and emits a
// one-cycle pulse for each selected edge.
module tmr_edge_sync
  import tmr_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  input  logic edge_sel,
  output logic event_pulse
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   cur;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign cur = sync_q[SYNC_STAGES-1];

  always_comb begin
    event_pulse = 1'b0;
    if (edge_sel_e'(edge_sel) == EDGE_FALL) event_pulse = prev_q & ~cur;
    else                                    event_pulse = cur & ~prev_q;
  end

endmodule

// File: rtl/tmr_param.sv
// PIC16F84A-style timer: internal/external event source, power-of-two
// prescaler, write with increment inhibit, sticky overflow flag and pulses.
module tmr_param
  import tmr_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned PS_BITS     = 3,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic               oscIn,
  input  logic               reset,
  input  logic               t0cki,
  input  logic               t0cs,
  input  logic               t0se,
  input  logic               psa,
  input  logic [PS_BITS-1:0] ps,
  input  logic               en,
  input  logic               wr_en,
  input  logic [WIDTH-1:0]   wr_data,
  input  logic               if_clr,
  output logic [WIDTH-1:0]   tmr_out,
  output logic               t0if,
  output logic               tick,
  output logic               ovf_pulse
);

  localparam int unsigned PSC_W = 1 << PS_BITS;
  localparam int unsigned INH_W = $clog2(INHIBIT_CYCLES + 1);

  logic [WIDTH-1:0] tmr;
  logic [PSC_W-1:0] psc;
  logic [PSC_W-1:0] psc_mask;
  logic [INH_W-1:0] inh;
  logic             flag_q;
  logic             tick_q;
  logic             ovf_q;
  logic             ext_evt;
  logic             evt;
  logic             inc_req;
  logic             do_inc;
  logic             wrap;

  tmr_edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_edge_sync (
    .clk        (oscIn),
    .reset      (reset),
    .din        (t0cki),
    .edge_sel   (t0se),
    .event_pulse(ext_evt)
  );

  always_comb begin
    psc_mask = '0;
    // Low ps+1 bits of psc must all be ones for the prescaler to fire
    for (int unsigned i = 0; i < PSC_W; i++) psc_mask[i] = (i <= 32'(ps));
    evt     = (src_sel_e'(t0cs) == SRC_EXT) ? ext_evt : 1'b1;
    inc_req = evt & (psa | ((psc & psc_mask) == psc_mask));
    do_inc  = en & inc_req & (inh == '0) & ~wr_en;
    wrap    = do_inc & (tmr == '1);
  end

  always_ff @(posedge oscIn) begin
    if (reset) begin
      tmr    <= '0;
      psc    <= '0;
      inh    <= '0;
      flag_q <= 1'b0;
      tick_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      if (wr_en)           psc <= '0;
      else if (en && evt)  psc <= psc + 1'b1;

      if (wr_en)           inh <= INH_W'(INHIBIT_CYCLES);
      else if (inh != '0)  inh <= inh - 1'b1;

      if (wr_en)           tmr <= wr_data;
      else if (do_inc)     tmr <= tmr + 1'b1;

      if (wrap)            flag_q <= 1'b1;
      else if (if_clr)     flag_q <= 1'b0;

      tick_q <= do_inc;
      ovf_q  <= wrap;
    end
  end

  assign tmr_out   = tmr;
  assign t0if      = flag_q;
  assign tick      = tick_q;
  assign ovf_pulse = ovf_q;

endmodule

// File: tb/tb_tmr_param.sv
// Self-checking bench for tmr_param: directed table, corner sequences and
// randomized stimulus against a rule-level reference model.
module tb_tmr_param;
  import tmr_pkg::*;

  localparam int W     = 8;
  localparam int PSB   = 3;
  localparam int S     = 2;
  localparam int TMOD  = 1 << W;
  localparam int PSMOD = 1 << (1 << PSB);

  logic           oscIn = 1'b0;
  logic           reset = 1'b0;
  logic           t0cki = 1'b0;
  logic           t0cs  = 1'b0;
  logic           t0se  = 1'b0;
  logic           psa   = 1'b1;
  logic [PSB-1:0] ps    = '0;
  logic           en    = 1'b0;
  logic           wr_en = 1'b0;
  logic [W-1:0]   wr_data = '0;
  logic           if_clr = 1'b0;
  logic [W-1:0]   tmr_out;
  logic           t0if, tick, ovf_pulse;

  tmr_param #(.WIDTH(W), .PS_BITS(PSB), .SYNC_STAGES(S)) dut (
    .oscIn(oscIn), .reset(reset), .t0cki(t0cki), .t0cs(t0cs), .t0se(t0se),
    .psa(psa), .ps(ps), .en(en), .wr_en(wr_en), .wr_data(wr_data),
    .if_clr(if_clr), .tmr_out(tmr_out), .t0if(t0if), .tick(tick),
    .ovf_pulse(ovf_pulse)
  );

  always #5 oscIn = ~oscIn;

  int errors = 0;
  int checks = 0;
  bit cmp_model = 1'b0;

  // Reference model state; hist[0] is the most recently sampled pin value
  int m_tmr, m_psc, m_inh;
  bit m_if, m_tick, m_ovf;
  bit hist [0:S];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic model_edge();
    bit ev, req, inc, wrp;
    int ratio;
    if (reset) begin
      m_tmr = 0; m_psc = 0; m_inh = 0; m_if = 0; m_tick = 0; m_ovf = 0;
      for (int i = 0; i <= S; i++) hist[i] = 1'b0;
    end else begin
      if (t0cs) ev = t0se ? (hist[S] && !hist[S-1]) : (!hist[S] && hist[S-1]);
      else      ev = 1'b1;
      ratio = int'(ps_ratio(32'(ps)));
      req = ev && (psa || (m_psc % ratio) == ratio - 1);
      inc = en && req && (m_inh == 0) && !wr_en;
      wrp = inc && (m_tmr == TMOD - 1);
      if (wr_en)         m_psc = 0;
      else if (en && ev) m_psc = (m_psc + 1) % PSMOD;
      if (wr_en)         m_tmr = int'(wr_data);
      else if (inc)      m_tmr = (m_tmr + 1) % TMOD;
      if (wr_en)         m_inh = 2;
      else if (m_inh > 0) m_inh = m_inh - 1;
      if (wrp)           m_if = 1'b1;
      else if (if_clr)   m_if = 1'b0;
      m_tick = inc;
      m_ovf  = wrp;
      for (int i = S; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = t0cki;
    end
  endtask

  task automatic step();
    @(posedge oscIn);
    model_edge();
    #1;
    if (cmp_model) begin
      check("model_tmr",  int'(tmr_out),   m_tmr);
      check("model_t0if", int'(t0if),      int'(m_if));
      check("model_tick", int'(tick),      int'(m_tick));
      check("model_ovf",  int'(ovf_pulse), int'(m_ovf));
      check("model_psc",  int'(dut.psc),   m_psc);
    end
  endtask

  typedef struct packed {
    logic       rst;
    logic       en;
    logic       wr;
    logic [7:0] wdata;
    logic       clr;
    logic [7:0] e_tmr;
    logic       e_if;
    logic       e_tick;
    logic       e_ovf;
  } vec_t;

  vec_t tbl [22];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ovf_cnt, tick_cnt, hold;

    //             rst   en    wr    wdata  clr   tmr    if    tick  ovf
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 1'b1, 8'hFE, 1'b0, 8'hFE, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'hFE, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'hFE, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'hFF, 1'b0, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h01, 1'b1, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h02, 1'b0, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 1'b1, 8'hFF, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 1'b1, 8'hFE, 1'b0, 8'hFE, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'hFE, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'hFE, 1'b0, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'hFF, 1'b0, 1'b1, 1'b0};
    tbl[13] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h00, 1'b1, 1'b1, 1'b1};
    tbl[14] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h01, 1'b0, 1'b1, 1'b0};
    tbl[15] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h01, 1'b0, 1'b0, 1'b0};
    tbl[16] = '{1'b0, 1'b0, 1'b1, 8'h7F, 1'b0, 8'h7F, 1'b0, 1'b0, 1'b0};
    tbl[17] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h7F, 1'b0, 1'b0, 1'b0};
    tbl[18] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h7F, 1'b0, 1'b0, 1'b0};
    tbl[19] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0};
    tbl[20] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
    tbl[21] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h01, 1'b0, 1'b1, 1'b0};

    // Table: write inhibit, restart, set/clear collision, enable, reset
    t0cs = 1'b0; psa = 1'b1; ps = '0; t0cki = 1'b0;
    for (int i = 0; i < 22; i++) begin
      reset = tbl[i].rst; en = tbl[i].en; wr_en = tbl[i].wr;
      wr_data = tbl[i].wdata; if_clr = tbl[i].clr;
      step();
      check($sformatf("tbl%0d_tmr", i),  int'(tmr_out),   int'(tbl[i].e_tmr));
      check($sformatf("tbl%0d_t0if", i), int'(t0if),      int'(tbl[i].e_if));
      check($sformatf("tbl%0d_tick", i), int'(tick),      int'(tbl[i].e_tick));
      check($sformatf("tbl%0d_ovf", i),  int'(ovf_pulse), int'(tbl[i].e_ovf));
    end
    wr_en = 1'b0; if_clr = 1'b0;

    // Internal 1:1 for 300 cycles
    reset = 1'b1; en = 1'b1; step(); reset = 1'b0;
    ovf_cnt = 0;
    for (int n = 1; n <= 300; n++) begin
      step();
      if (ovf_pulse) ovf_cnt++;
      if (n == 255) check("int_tmr_255", int'(tmr_out), 255);
      if (n == 256) begin
        check("int_wrap_tmr", int'(tmr_out), 0);
        check("int_wrap_t0if", int'(t0if), 1);
        check("int_wrap_ovf", int'(ovf_pulse), 1);
      end
      if (n == 257) check("int_ovf_one_cycle", int'(ovf_pulse), 0);
    end
    check("int_ovf_count", ovf_cnt, 1);
    check("int_tmr_300", int'(tmr_out), 300 % 256);

    // Prescale 1:8 for 40 cycles
    psa = 1'b0; ps = 3'd2;
    reset = 1'b1; step(); reset = 1'b0;
    tick_cnt = 0;
    for (int n = 1; n <= 40; n++) begin
      step();
      if (tick) begin
        tick_cnt++;
        check("ps8_tick_spacing", n % 8, 0);
      end
    end
    check("ps8_tmr", int'(tmr_out), 5);
    check("ps8_tick_count", tick_cnt, 5);

    // External falling edges, 4 high / 4 low
    t0cs = 1'b1; t0se = 1'b1; psa = 1'b1; t0cki = 1'b0;
    reset = 1'b1; step(); reset = 1'b0;
    for (int p = 0; p < 10; p++) begin
      t0cki = 1'b1;
      for (int c = 0; c < 4; c++) step();
      check("ext_rise_ignored", int'(tmr_out), p);
      t0cki = 1'b0;
      step();
      step();
      check("ext_not_early", int'(tmr_out), p);
      step();
      check("ext_update", int'(tmr_out), p + 1);
      step();
    end
    check("ext_total", int'(tmr_out), 10);

    // Enable hold with prescaler mid-count, checked against the model
    t0cs = 1'b0; psa = 1'b0; ps = 3'd1;
    reset = 1'b1; step(); reset = 1'b0;
    cmp_model = 1'b1;
    for (int n = 0; n < 13; n++) step();
    en = 1'b0;
    for (int n = 0; n < 20; n++) step();
    en = 1'b1;
    for (int n = 0; n < 10; n++) step();

    // Randomized stimulus
    hold = 2;
    for (int n = 0; n < 4000; n++) begin
      if (hold == 0) begin
        t0cki = ~t0cki;
        hold = $urandom_range(5, 2);
      end
      if ($urandom_range(99, 0) < 2) t0cs = ~t0cs;
      if ($urandom_range(99, 0) < 2) t0se = ~t0se;
      if ($urandom_range(99, 0) < 3) psa  = ~psa;
      if ($urandom_range(99, 0) < 2) ps   = PSB'($urandom_range(2, 0));
      en      = ($urandom_range(9, 0) != 0);
      wr_en   = ($urandom_range(99, 0) < 3);
      wr_data = ($urandom_range(1, 0) == 1) ? W'($urandom_range(255, 250)) : W'($urandom);
      if_clr  = ($urandom_range(99, 0) < 5);
      reset   = ($urandom_range(499, 0) == 0);
      step();
      hold--;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
